// File: rtl/ap_fifo_downsizer_if.sv
// ap_fifo write-side and read-side signals of the downsizer, plus its status outputs.
interface ap_fifo_downsizer_if #(
  parameter int IN_W   = 128,
  parameter int OUT_W  = 32,
  parameter int ADDR_W = 2
);
  logic [IN_W-1:0]   in_din;
  logic              in_write;
  logic              in_full_n;
  logic [OUT_W-1:0]  out_dout;
  logic              out_empty_n;
  logic              out_read;
  logic [ADDR_W:0]   level;
  logic              err_overflow;
  logic              err_underflow;

  // Producer/consumer side (IP core plus host stream, or a testbench).
  modport master (
    output in_din, in_write, out_read,
    input  in_full_n, out_dout, out_empty_n, level, err_overflow, err_underflow
  );

  // The downsizer itself.
  modport slave (
    input  in_din, in_write, out_read,
    output in_full_n, out_dout, out_empty_n, level, err_overflow, err_underflow
  );
endinterface

// File: rtl/ap_fifo_downsizer.sv
// ap_fifo downsizer: buffers IN_W-bit words and presents them as OUT_W-bit lanes,
// lowest lane first, with show-ahead read data.
module ap_fifo_downsizer #(
  parameter int IN_W   = 128,
  parameter int OUT_W  = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input logic                ap_clk,
  input logic                ap_rst,
  ap_fifo_downsizer_if.slave bus
);

  localparam int RATIO  = IN_W / OUT_W;
  localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(RATIO - 1);
  localparam logic [ADDR_W:0]   FULL_LVL  = (ADDR_W + 1)'(DEPTH);

  logic [IN_W-1:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              live_q;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic full_n, empty_n, wr_en, rd_en, pop_word;

  // Flags decoded from the registered level; live_q holds full_n low during reset
  // and releases it on the first edge after reset drops.
  always_comb begin
    full_n   = live_q & (level_q != FULL_LVL);
    empty_n  = (level_q != '0);
    wr_en    = bus.in_write & full_n;
    rd_en    = bus.out_read & empty_n;
    pop_word = rd_en & (lane_q == LAST_LANE);
  end

  // Next-state for pointers, lane counter, level and sticky errors.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    lane_d   = lane_q;
    level_d  = level_q;
    ovf_d    = ovf_q | (bus.in_write & ~full_n);
    unf_d    = unf_q | (bus.out_read & ~empty_n);
    if (wr_en) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (rd_en) begin
      if (lane_q == LAST_LANE) begin
        lane_d   = '0;
        rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      end else begin
        lane_d = lane_q + LANE_W'(1);
      end
    end
    // Write and final-lane pop in the same cycle cancel out on the level.
    case ({wr_en, pop_word})
      2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
      2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Control state register, async reset.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      lane_q   <= '0;
      level_q  <= '0;
      live_q   <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      lane_q   <= lane_d;
      level_q  <= level_d;
      live_q   <= 1'b1;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Word storage; not cleared by reset.
  always_ff @(posedge ap_clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= bus.in_din;
    end
  end

  assign bus.out_dout      = mem_q[rd_ptr_q][int'(lane_q) * OUT_W +: OUT_W];
  assign bus.in_full_n     = full_n;
  assign bus.out_empty_n   = empty_n;
  assign bus.level         = level_q;
  assign bus.err_overflow  = ovf_q;
  assign bus.err_underflow = unf_q;

endmodule

// File: tb/tb_ap_fifo_downsizer.sv
// Self-checking bench for ap_fifo_downsizer: a lane-level scoreboard queue models
// contents, level and flags; every read-side lane is compared against it.
module tb_ap_fifo_downsizer;

  logic ap_clk;
  logic ap_rst;

  ap_fifo_downsizer_if #(.IN_W(128), .OUT_W(32), .ADDR_W(2)) bus ();

  ap_fifo_downsizer #(.IN_W(128), .OUT_W(32), .DEPTH(4), .ADDR_W(2)) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] sb[$];
  logic        m_ready;
  logic        m_ovf;
  logic        m_unf;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at posedge+1, check mid-cycle, update model, advance.
  task automatic step(input logic wr, input logic [127:0] d, input logic rd);
    logic [2:0] e_lvl;
    logic       e_full_n, e_empty_n;
    bus.in_write = wr;
    bus.in_din   = d;
    bus.out_read = rd;
    e_lvl     = 3'((sb.size() + 3) / 4);
    e_empty_n = (sb.size() != 0);
    e_full_n  = m_ready && (e_lvl != 3'd4);
    #3;
    check("in_full_n", bus.in_full_n, e_full_n);
    check("out_empty_n", bus.out_empty_n, e_empty_n);
    check("level", bus.level, e_lvl);
    check("err_overflow", bus.err_overflow, m_ovf);
    check("err_underflow", bus.err_underflow, m_unf);
    if (rd && e_empty_n) check("out_dout", bus.out_dout, sb[0]);
    if (wr && !e_full_n) m_ovf = 1'b1;
    if (rd && !e_empty_n) m_unf = 1'b1;
    if (rd && e_empty_n) void'(sb.pop_front());
    if (wr && e_full_n) begin
      for (int k = 0; k < 4; k++) sb.push_back(d[k*32 +: 32]);
    end
    @(posedge ap_clk);
    #1;
    m_ready      = 1'b1;
    bus.in_write = 1'b0;
    bus.out_read = 1'b0;
  endtask

  // Assert reset asynchronously, check the immediate flag state, release after an edge.
  task automatic do_reset();
    ap_rst = 1'b1;
    sb.delete();
    m_ready = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    #1;
    check("rst_level", bus.level, 3'd0);
    check("rst_empty_n", bus.out_empty_n, 1'b0);
    check("rst_full_n", bus.in_full_n, 1'b0);
    check("rst_ovf", bus.err_overflow, 1'b0);
    check("rst_unf", bus.err_underflow, 1'b0);
    @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
    m_ready = 1'b1;
  endtask

  initial begin
    ap_rst       = 1'b1;
    bus.in_din   = '0;
    bus.in_write = 1'b0;
    bus.out_read = 1'b0;
    m_ready = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    #1;
    do_reset();

    // 1: single word, four consecutive lane pops, then empty.
    step(1'b1, 128'h44444444_33333333_22222222_11111111, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // 2: fill with four words, fifth write rejected, read all back.
    do_reset();
    for (int w = 1; w <= 4; w++) step(1'b1, {4{32'(w * 16'h0101)}} ^ 128'h0000000F_00000007_00000003_00000001, 1'b0);
    step(1'b1, {4{32'hDEADBEEF}}, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // 3: full, write on the final-lane pop of the head is still rejected.
    do_reset();
    for (int w = 0; w < 4; w++) step(1'b1, {32'hA0 + 32'(w), 32'hB0, 32'hC0, 32'hD0 + 32'(w)}, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    step(1'b1, {4{32'h55AA55AA}}, 1'b1);
    step(1'b0, '0, 1'b0);

    // 4: steady state, level 2, one write per four pops.
    do_reset();
    step(1'b1, {32'h04, 32'h03, 32'h02, 32'h01}, 1'b0);
    step(1'b1, {32'h14, 32'h13, 32'h12, 32'h11}, 1'b0);
    for (int i = 0; i < 24; i++) begin
      step((i % 4) == 0, {4{$urandom}}, 1'b1);
    end
    for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1);

    // 5: read from an empty FIFO sets the underflow flag only.
    do_reset();
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // 6: reset after two lanes popped, next word starts at lane 0.
    do_reset();
    step(1'b1, {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000}, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    do_reset();
    step(1'b0, '0, 1'b0);
    step(1'b1, {32'h9999_0003, 32'h9999_0002, 32'h9999_0001, 32'h9999_0000}, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
